// File: rtl/dmem_pkg.sv
// Shared widths, store-buffer entry layout and request encoding for the data memory.
// Pure declarations; no timing or flow control of its own.
package dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int DATA_W    = 32;
  localparam int IDX_W_MAX = WORD_W - 2;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } req_e;

  // idx is kept at full word-index width and zero-extended so entries compare uniformly.
  typedef struct packed {
    logic                 valid;
    logic [IDX_W_MAX-1:0] idx;
    logic [DATA_W-1:0]    data;
  } sb_entry_t;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store buffer with push/pop and a parallel index compare returning the youngest hit.
// Pop and compare are combinational off registered state; push and pop are never issued together.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int CNT_W    = $clog2(SB_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [IDX_W_MAX-1:0] i_push_idx,
  input  logic [DATA_W-1:0]    i_push_dat,
  input  logic                 i_pop,
  input  logic [IDX_W_MAX-1:0] i_cmp_idx,
  output sb_entry_t            o_head,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_hit,
  output logic [DATA_W-1:0]    o_hit_dat
);

  localparam int PW = $clog2(SB_DEPTH);

  sb_entry_t        r_ent [SB_DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PW-1:0]    w_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (i_push && !i_pop) begin
      r_ent[r_tail] <= '{valid: 1'b1, idx: i_push_idx, data: i_push_dat};
      r_tail        <= r_tail + PW'(1);
      r_count       <= r_count + CNT_W'(1);
    end else if (i_pop && !i_push) begin
      r_ent[r_head].valid <= 1'b0;
      r_head              <= r_head + PW'(1);
      r_count             <= r_count - CNT_W'(1);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_dat = '0;
    w_slot    = r_head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_slot = r_head + PW'(i);
      if (r_ent[w_slot].valid && (r_ent[w_slot].idx == i_cmp_idx)) begin
        o_hit     = 1'b1;
        o_hit_dat = r_ent[w_slot].data;
      end
    end
  end

  assign o_head  = r_ent[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/dmem_store_buf.sv
// Word-addressed data RAM with posted in-order store buffer; loads return in the same cycle.
// Stall on store into a full buffer (macro DMEM_SB_FWD_EN enables forwarding; else matching loads stall).
module dmem_store_buf
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int SB_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WORD_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_write,
  input  logic                           mem_read,
  output logic [DATA_W-1:0]              read_data,
  output logic                           stall,
  output logic [$clog2(SB_DEPTH+1)-1:0]  sb_count,
  output logic                           sb_empty
);

  localparam int IDXW  = idx_width(DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  logic [DATA_W-1:0]    r_ram [DEPTH];
  logic [IDXW-1:0]      w_idx;
  logic [IDX_W_MAX-1:0] w_idx_ext;
  req_e                 w_req;
  sb_entry_t            w_head;
  logic                 w_hit;
  logic [DATA_W-1:0]    w_hit_dat;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_stall_raw;
  logic                 w_drain;
  logic                 w_push;
  logic [DATA_W-1:0]    w_load_dat;
  logic                 w_unused;

  assign w_idx     = mem_addr[IDXW+1:2];
  assign w_idx_ext = IDX_W_MAX'(w_idx);

  // A load wins when both requests are raised; the store is simply dropped.
  always_comb begin
    w_req = REQ_IDLE;
    if (mem_read) begin
      w_req = REQ_LOAD;
    end else if (mem_write) begin
      w_req = REQ_STORE;
    end
  end

  sb_fifo #(
    .SB_DEPTH (SB_DEPTH),
    .CNT_W    (CNT_W)
  ) u_sb_fifo (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_push     (w_push),
    .i_push_idx (w_idx_ext),
    .i_push_dat (mem_wdata),
    .i_pop      (w_drain),
    .i_cmp_idx  (w_idx_ext),
    .o_head     (w_head),
    .o_count    (sb_count),
    .o_hit      (w_hit),
    .o_hit_dat  (w_hit_dat)
  );

  assign w_full  = (sb_count == CNT_W'(SB_DEPTH));
  assign w_empty = (sb_count == '0);

`ifdef DMEM_SB_FWD_EN
  assign w_stall_raw = (w_req == REQ_STORE) && w_full;
  assign w_load_dat  = w_hit ? w_hit_dat : r_ram[w_idx];
  assign w_unused    = ^{mem_addr[1:0], mem_addr[WORD_W-1:IDXW+2], w_head.valid,
                         w_head.idx[IDX_W_MAX-1:IDXW]};
`else
  // Without forwarding, a load that aliases a pending store waits for it to drain.
  assign w_stall_raw = ((w_req == REQ_STORE) && w_full) || ((w_req == REQ_LOAD) && w_hit);
  assign w_load_dat  = r_ram[w_idx];
  assign w_unused    = ^{mem_addr[1:0], mem_addr[WORD_W-1:IDXW+2], w_head.valid,
                         w_head.idx[IDX_W_MAX-1:IDXW], w_hit_dat};
`endif

  // The RAM port is free on idle cycles and on stalled cycles.
  assign stall     = reset && w_stall_raw;
  assign w_drain   = reset && !w_empty && (stall || (w_req == REQ_IDLE));
  assign w_push    = reset && (w_req == REQ_STORE) && !w_full;
  assign read_data = (reset && (w_req == REQ_LOAD) && !stall) ? w_load_dat : '0;
  assign sb_empty  = w_empty;

  always_ff @(posedge clk) begin
    if (w_drain) begin
      r_ram[w_head.idx[IDXW-1:0]] <= w_head.data;
    end
  end

endmodule

// File: tb/tb_dmem_store_buf.sv
// Bench for dmem_store_buf: directed scenarios plus randomized traffic against a queue-based model.
module tb_dmem_store_buf;

  localparam int SB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        stall;
  logic [2:0]  sb_count;
  logic        sb_empty;

  dmem_store_buf #(.DEPTH(256), .SB_DEPTH(SB)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .read_data (read_data),
    .stall     (stall),
    .sb_count  (sb_count),
    .sb_empty  (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [31:0] dat;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_ram [256];
  bit          m_known [256];

  bit          exp_stall;
  logic [31:0] exp_rdata;
  bit          exp_known;
  logic [2:0]  exp_cnt;
  bit          p_drain;
  bit          p_push;
  int unsigned p_ix;
  logic [31:0] p_dat;

  int n_cmp = 0;
  int n_bad = 0;

  // Drive one request at the falling edge and predict this cycle's outputs from the model.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned ix;
    bit          match;
    logic [31:0] ydat;
    bit          ld;
    bit          st;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    ix    = (a >> 2) % 256;
    ld    = rd;
    st    = wr && !rd;
    match = 1'b0;
    ydat  = '0;
    foreach (q[k]) begin
      if (q[k].idx == ix) begin
        match = 1'b1;
        ydat  = q[k].dat;
      end
    end
`ifdef DMEM_SB_FWD_EN
    exp_stall = st && (q.size() == SB);
`else
    exp_stall = (st && (q.size() == SB)) || (ld && match);
`endif
    exp_known = 1'b1;
    exp_rdata = '0;
    if (ld && !exp_stall) begin
`ifdef DMEM_SB_FWD_EN
      if (match) begin
        exp_rdata = ydat;
      end else begin
        exp_rdata = m_ram[ix];
        exp_known = m_known[ix];
      end
`else
      exp_rdata = m_ram[ix];
      exp_known = m_known[ix];
`endif
    end
    exp_cnt = 3'(q.size());
    p_drain = (q.size() != 0) && (exp_stall || (!ld && !st));
    p_push  = st && (q.size() < SB);
    p_ix    = ix;
    p_dat   = d;
    #2;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (p_drain) begin
      m_ram[q[0].idx]   = q[0].dat;
      m_known[q[0].idx] = 1'b1;
      void'(q.pop_front());
    end
    if (p_push) q.push_back('{p_ix, p_dat});
    p_drain = 1'b0;
    p_push  = 1'b0;
  endtask

  task automatic drain_all();
    for (int t = 0; t < 12 && q.size() != 0; t++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      advance();
    end
    n_cmp++;
    if (sb_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_all sb_empty got=%b exp=1 (count=%0d)", sb_empty, sb_count);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 32'h10;
    mem_wdata = 32'h1234;
    #3;
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_cmp++; if (sb_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", sb_count); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic test_store_load_fwd();
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    advance();
    step(1'b1, 1'b0, 32'h10, 32'h0);
`ifdef DMEM_SB_FWD_EN
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fwd_rdata got=%h exp=deadbeef", read_data); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fwd_stall got=%b exp=0", stall); end
    n_cmp++; if (sb_count !== 3'd1) begin n_bad++; $display("FAIL fwd_count got=%0d exp=1", sb_count); end
    advance();
`else
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_stall1 got=%b exp=1", stall); end
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL nofwd_rdata1 got=%h exp=0", read_data); end
    advance();
    step(1'b1, 1'b0, 32'h10, 32'h0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nofwd_stall2 got=%b exp=0", stall); end
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL nofwd_rdata2 got=%h exp=deadbeef", read_data); end
    n_cmp++; if (sb_count !== 3'd0) begin n_bad++; $display("FAIL nofwd_count got=%0d exp=0", sb_count); end
    advance();
`endif
    drain_all();
  endtask

  task automatic test_youngest();
    bit          got;
    logic [31:0] rdv;
    got = 1'b0;
    rdv = '0;
    step(1'b0, 1'b1, 32'h20, 32'h1);
    advance();
    step(1'b0, 1'b1, 32'h20, 32'h2);
    advance();
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 1'b0, 32'h20, 32'h0);
      if (stall === 1'b0) begin
        got = 1'b1;
        rdv = read_data;
      end
      advance();
      if (got) break;
    end
    n_cmp++; if (!got || rdv !== 32'h2) begin n_bad++; $display("FAIL youngest_rdata got=%h exp=2 (accepted=%0d)", rdv, got); end
    step(1'b0, 1'b0, 32'h0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 32'h0);
    advance();
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL youngest_empty got=%b exp=1", sb_empty); end
    step(1'b1, 1'b0, 32'h20, 32'h0);
    n_cmp++; if (read_data !== 32'h2) begin n_bad++; $display("FAIL youngest_ram got=%h exp=2", read_data); end
    advance();
  endtask

  task automatic test_full();
    drain_all();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'(i * 4), 32'h100 + 32'(i));
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL full_fill%0d stall got=%b exp=0", i, stall); end
      advance();
    end
    step(1'b0, 1'b1, 32'h10, 32'h104);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got=%b exp=1", stall); end
    n_cmp++; if (sb_count !== 3'd4) begin n_bad++; $display("FAIL full_count4 got=%0d exp=4", sb_count); end
    advance();
    step(1'b0, 1'b1, 32'h10, 32'h104);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL full_release got=%b exp=0", stall); end
    n_cmp++; if (sb_count !== 3'd3) begin n_bad++; $display("FAIL full_count3 got=%0d exp=3", sb_count); end
    advance();
    n_cmp++; if (sb_count !== 3'd4) begin n_bad++; $display("FAIL full_after got=%0d exp=4", sb_count); end
    drain_all();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'(i * 4), 32'h0);
      n_cmp++; if (read_data !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL full_rd%0d got=%h exp=%h", i, read_data, 32'h100 + 32'(i)); end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] vals [10];
    for (int i = 0; i < 10; i++) begin
      vals[i] = $urandom;
      step(1'b0, 1'b1, 32'h300 + 32'(i * 4), vals[i]);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL wrap_stall%0d got=%b exp=0", i, stall); end
      advance();
      step(1'b0, 1'b0, 32'h0, 32'h0);
      advance();
    end
    drain_all();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0);
      n_cmp++; if (read_data !== vals[i]) begin n_bad++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, read_data, vals[i]); end
      advance();
    end
  endtask

  task automatic test_both_high();
    drain_all();
    step(1'b0, 1'b1, 32'h40, 32'hA5A50001);
    advance();
    drain_all();
    step(1'b0, 1'b1, 32'h80, 32'h77);
    advance();
    step(1'b1, 1'b1, 32'h40, 32'h55);
    n_cmp++; if (read_data !== 32'hA5A50001) begin n_bad++; $display("FAIL both_rdata got=%h exp=a5a50001", read_data); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL both_stall got=%b exp=0", stall); end
    advance();
    n_cmp++; if (sb_count !== 3'd1) begin n_bad++; $display("FAIL both_count got=%0d exp=1", sb_count); end
    drain_all();
    step(1'b1, 1'b0, 32'h40, 32'h0);
    n_cmp++; if (read_data !== 32'hA5A50001) begin n_bad++; $display("FAIL both_dropped got=%h exp=a5a50001", read_data); end
    advance();
  endtask

  task automatic test_reset_mid();
    drain_all();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'h11 * 32'(i + 1));
      advance();
    end
    drain_all();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'hB1 + 32'(i));
      advance();
    end
    @(negedge clk);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h200;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (sb_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count got=%0d exp=0", sb_count); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty got=%b exp=1", sb_empty); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got=%h exp=0", read_data); end
    q.delete();
    p_drain = 1'b0;
    p_push  = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0);
      n_cmp++; if (read_data !== 32'h11 * 32'(i + 1)) begin n_bad++; $display("FAIL rstmid_lost%0d got=%h exp=%h", i, read_data, 32'h11 * 32'(i + 1)); end
      advance();
    end
  endtask

  task automatic test_random();
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          hold;
    int          op;
    hold = 1'b0;
    rd   = 1'b0;
    wr   = 1'b0;
    a    = '0;
    d    = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        op = $urandom_range(0, 9);
        rd = (op >= 4 && op <= 6) || op == 9;
        wr = (op <= 3) || op == 9;
        a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 12);
        d  = $urandom;
      end
      step(rd, wr, a, d);
      n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, exp_stall); end
      n_cmp++; if (sb_count !== exp_cnt) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, sb_count, exp_cnt); end
      n_cmp++; if (sb_empty !== (exp_cnt == 3'd0)) begin n_bad++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", c, sb_empty, exp_cnt == 3'd0); end
      if (exp_known) begin
        n_cmp++; if (read_data !== exp_rdata) begin n_bad++; $display("FAIL rnd_rdata cyc=%0d addr=%h got=%h exp=%h", c, a, read_data, exp_rdata); end
      end
      hold = exp_stall;
      advance();
    end
  endtask

  initial begin
    p_drain   = 1'b0;
    p_push    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    test_reset();
    test_store_load_fwd();
    test_youngest();
    test_full();
    test_wrap();
    test_both_high();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
